// File: rtl/refcpu_fetch.sv
// Instruction fetch unit: holds the PC, issues one request at a time and hands words to decode.
// Optional REFCPU_FETCH_ALIGN_CHECK_EN turns a misaligned PC into an address-error slot instead of a bus request.
module refcpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  output logic        inst_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        adel_q, adel_d;
  // Set for the cycle after each sampled reset so outputs stay quiet while reset is held.
  logic        rst_q;
  logic        misalign;
  logic        req_fire;

`ifdef REFCPU_FETCH_ALIGN_CHECK_EN
  assign misalign  = (pc_q[1:0] != 2'b00);
  assign ireq_addr = pc_q;
`else
  assign misalign  = 1'b0;
  assign ireq_addr = {pc_q[31:2], 2'b00};
`endif

  assign ireq_valid = (state_q == S_REQ) && !rst_q && !misalign;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_adel  = adel_q;
  assign req_fire   = ireq_valid && ireq_addr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      adel_q    <= 1'b0;
      rst_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      adel_q    <= adel_d;
      rst_q     <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    adel_d    = adel_q;
    unique case (state_q)
      S_REQ: begin
        // Redirect wins; an address accepted in the same cycle must be flushed.
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (req_fire) state_d = S_FLUSH;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end else if (misalign && !rst_q) begin
          state_d   = S_HOLD;
          inst_d    = 32'h0;
          inst_pc_d = pc_q;
          adel_d    = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = iresp_data_ok ? S_REQ : S_FLUSH;
        end else if (iresp_data_ok) begin
          inst_d    = iresp_data;
          inst_pc_d = pc_q;
          adel_d    = 1'b0;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_FLUSH: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (iresp_data_ok) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

endmodule

// File: tb/tb_refcpu_fetch.sv
// Directed bench for refcpu_fetch: stimulus pushes expected requests/instructions, a monitor pops on handshakes.
module tb_refcpu_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        inst_adel;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic        adel;
  } inst_exp_t;

  logic [31:0] exp_addr_q[$];
  inst_exp_t   exp_inst_q[$];
  int n_chk = 0;
  int n_fail = 0;

  refcpu_fetch dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_addr_ok(ireq_addr_ok),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst(inst), .inst_adel(inst_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic rv, input logic [31:0] rpc, input logic aok,
                     input logic dok, input logic [31:0] d, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    ireq_addr_ok   = aok;
    iresp_data_ok  = dok;
    iresp_data     = d;
    inst_ready     = rdy;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_inst(input logic [31:0] w, input logic [31:0] p, input logic a);
    inst_exp_t e;
    e.word = w; e.pc = p; e.adel = a;
    exp_inst_q.push_back(e);
  endtask

  // Monitor: inputs settle right after the falling edge, so sample a little later.
  initial begin
    inst_exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #2;
      if (ireq_valid && ireq_addr_ok) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_req", ireq_addr, 32'hxxxx_xxxx);
        end else begin
          a = exp_addr_q.pop_front();
          chk("req_addr", ireq_addr, a);
        end
      end
      if (inst_valid && inst_ready) begin
        if (exp_inst_q.size() == 0) begin
          chk("unexpected_inst", inst, 32'hxxxx_xxxx);
        end else begin
          e = exp_inst_q.pop_front();
          chk("inst_word", inst, e.word);
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_adel", {31'h0, inst_adel}, {31'h0, e.adel});
        end
      end
    end
  end

  initial begin
    tick(); tick();
    chk("rst_ireq_valid", {31'h0, ireq_valid}, 32'h0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_ireq_addr", ireq_addr, 32'hbfc0_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_adel", {31'h0, inst_adel}, 32'h0);
    reset = 1'b0;
    tick();
    chk("first_req_valid", {31'h0, ireq_valid}, 32'h1);

    // Back-to-back 3-cycle loop
    drv(0, 0, 1, 0, 0, 0); exp_addr_q.push_back(32'hbfc0_0000); tick();
    drv(0, 0, 1, 1, 32'h0000_0020, 0); push_inst(32'h0000_0020, 32'hbfc0_0000, 0); tick();
    chk("hold_valid", {31'h0, inst_valid}, 32'h1);
    drv(0, 0, 1, 0, 0, 1); tick();
    chk("loop_req_valid", {31'h0, ireq_valid}, 32'h1);
    chk("loop_req_addr", ireq_addr, 32'hbfc0_0004);

    // Decode stall for 5 cycles
    drv(0, 0, 1, 0, 0, 0); exp_addr_q.push_back(32'hbfc0_0004); tick();
    drv(0, 0, 0, 1, 32'h1234_5678, 0); push_inst(32'h1234_5678, 32'hbfc0_0004, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0, 0, 0, 0);
      chk("stall_valid", {31'h0, inst_valid}, 32'h1);
      chk("stall_inst", inst, 32'h1234_5678);
      chk("stall_pc", inst_pc, 32'hbfc0_0004);
      chk("stall_no_req", {31'h0, ireq_valid}, 32'h0);
      tick();
    end
    drv(0, 0, 0, 0, 0, 1); tick();
    chk("stall_next_addr", ireq_addr, 32'hbfc0_0008);

    // Redirect in S_WAIT, stale response two cycles later
    drv(0, 0, 1, 0, 0, 0); exp_addr_q.push_back(32'hbfc0_0008); tick();
    drv(1, 32'h8000_0100, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0); tick();
    chk("flush_no_valid", {31'h0, inst_valid}, 32'h0);
    drv(0, 0, 0, 1, 32'hdead_beef, 0); tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("flush_drop_valid", {31'h0, inst_valid}, 32'h0);
    chk("redir_req_valid", {31'h0, ireq_valid}, 32'h1);
    chk("redir_req_addr", ireq_addr, 32'h8000_0100);
    drv(0, 0, 1, 0, 0, 0); exp_addr_q.push_back(32'h8000_0100); tick();
    drv(0, 0, 0, 1, 32'h0000_0111, 0); push_inst(32'h0000_0111, 32'h8000_0100, 0); tick();
    drv(0, 0, 0, 0, 0, 1); tick();

    // Redirect coincident with response in S_WAIT
    drv(0, 0, 1, 0, 0, 0); exp_addr_q.push_back(32'h8000_0104); tick();
    drv(1, 32'h0000_4000, 0, 1, 32'hcafe_f00d, 0); tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("coinc_no_valid", {31'h0, inst_valid}, 32'h0);
    chk("coinc_req_valid", {31'h0, ireq_valid}, 32'h1);
    chk("coinc_req_addr", ireq_addr, 32'h0000_4000);

    // Redirect coincident with address acceptance in S_REQ
    drv(1, 32'h0000_0100, 1, 0, 0, 0); exp_addr_q.push_back(32'h0000_4000); tick();
    drv(0, 0, 0, 1, 32'h0bad_c0de, 0);
    chk("racc_no_req", {31'h0, ireq_valid}, 32'h0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("racc_no_valid", {31'h0, inst_valid}, 32'h0);
    chk("racc_req_addr", ireq_addr, 32'h0000_0100);

    // PC wrap
    drv(1, 32'hffff_fffc, 0, 0, 0, 0); tick();
    chk("wrap_start_addr", ireq_addr, 32'hffff_fffc);
    drv(0, 0, 1, 0, 0, 0); exp_addr_q.push_back(32'hffff_fffc); tick();
    drv(0, 0, 0, 1, 32'h0000_000a, 0); push_inst(32'h0000_000a, 32'hffff_fffc, 0); tick();
    drv(0, 0, 0, 0, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("wrap_req_valid", {31'h0, ireq_valid}, 32'h1);
    chk("wrap_req_addr", ireq_addr, 32'h0000_0000);
    drv(0, 0, 1, 0, 0, 0); exp_addr_q.push_back(32'h0000_0000); tick();
    drv(0, 0, 0, 1, 32'h0000_000b, 0); push_inst(32'h0000_000b, 32'h0000_0000, 0); tick();
    drv(0, 0, 0, 0, 0, 1); tick();

`ifdef REFCPU_FETCH_ALIGN_CHECK_EN
    drv(1, 32'h8000_0102, 0, 0, 0, 0); tick();
    drv(0, 0, 1, 0, 0, 0);
    chk("adel_no_req", {31'h0, ireq_valid}, 32'h0);
    tick();
    drv(1, 32'h8000_0200, 0, 0, 0, 1); push_inst(32'h0, 32'h8000_0102, 1);
    chk("adel_valid", {31'h0, inst_valid}, 32'h1);
    chk("adel_flag", {31'h0, inst_adel}, 32'h1);
    tick();
    drv(0, 0, 1, 0, 0, 0); exp_addr_q.push_back(32'h8000_0200); tick();
    drv(0, 0, 0, 1, 32'h0000_0222, 0); push_inst(32'h0000_0222, 32'h8000_0200, 0); tick();
    drv(0, 0, 0, 0, 0, 1); tick();
`endif

    drv(0, 0, 0, 0, 0, 0); tick(); tick();
    chk("addr_queue_drained", exp_addr_q.size(), 32'h0);
    chk("inst_queue_drained", exp_inst_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/refcpu_fetch.md
# refcpu_fetch

Instruction fetch unit for the reference multi-cycle CPU: producer of the fetched instruction word that the decode step consumes from `t[0]`. Holds the PC and issues one-at-a-time requests on the instruction bus. Presents each returned word with its PC on a valid/ready handshake toward decode. Accepts PC redirects from branch/commit and discards any in-flight response made stale by a redirect.

## Interface
- `RESET_PC`, default 32'hbfc0_0000: PC loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `redirect_valid`  in  1  load `redirect_pc` as the next fetch PC.
- `redirect_pc`  in  32  redirect target.
- `ireq_valid`  out  1  instruction bus request valid.
- `ireq_addr`  out  32  request address.
- `ireq_addr_ok`  in  1  request accepted; counts only when `ireq_valid`=1.
- `iresp_data_ok`  in  1  response valid; in order; at most one outstanding.
- `iresp_data`  in  32  response instruction word.
- `inst_valid`  out  1  fetched instruction available.
- `inst_ready`  in  1  decode consumes the instruction.
- `inst_pc`  out  32  PC of `inst`.
- `inst`  out  32  instruction word; `inst[31:26]` is the opcode.
- `inst_adel`  out  1  address-error flag (see Configuration).

## Operation
- Registers: `pc`, `inst_q`, `inst_pc_q`, `adel_q`, state in {S_REQ, S_WAIT, S_HOLD, S_FLUSH}.
- Reset: state=S_REQ, `pc`=RESET_PC, `inst_q`=0, `inst_pc_q`=0, `adel_q`=0.
- Output values in reset: `ireq_valid`=0, `inst_valid`=0, `ireq_addr`=RESET_PC, `inst`=0, `inst_pc`=0, `inst_adel`=0.
- Output decode: `ireq_valid`=1 only in S_REQ. `inst_valid`=1 only in S_HOLD. `ireq_addr`=`pc`. `inst`/`inst_pc`/`inst_adel` are driven from their registers.
- S_REQ:
  - `redirect_valid`: `pc`<=`redirect_pc`, stay. This takes priority over acceptance; an accepted address is then discarded by going to S_FLUSH.
  - `ireq_addr_ok` without redirect: go to S_WAIT.
  - `ireq_addr_ok` with redirect: go to S_FLUSH.
  - `iresp_data_ok` is ignored.
- S_WAIT:
  - `redirect_valid`: `pc`<=`redirect_pc`. If `iresp_data_ok` arrives in the same cycle, the data is dropped and the next state is S_REQ. Otherwise go to S_FLUSH.
  - `iresp_data_ok` without redirect: `inst_q`<=`iresp_data`, `inst_pc_q`<=`pc`, go to S_HOLD.
- S_HOLD:
  - `redirect_valid`: `pc`<=`redirect_pc`, go to S_REQ. The held word is dropped; if `inst_ready`=1 in that cycle, the handshake still counts for decode.
  - `inst_ready` without redirect: `pc`<=`pc`+4 (mod 2^32, wraps 32'hffff_fffc→0), go to S_REQ.
  - Otherwise hold all outputs stable.
- S_FLUSH:
  - On `iresp_data_ok`: discard the data, go to S_REQ.
  - `redirect_valid` here only updates `pc`.
- Reset asserted in any state returns to reset values in the next cycle. A response arriving afterwards in S_REQ is ignored; the bus side is reset together with the core.

## Timing
- Request visible the first cycle after reset deasserts.
- Minimum per-instruction loop is 3 cycles: request accepted (cycle N) → response (N+1) → `inst_valid` (N+2) with `inst_ready`=1 → next request (N+3).
- Response is never taken in the cycle its address is accepted.
- `ireq_addr` may change while `ireq_valid`=1 and not accepted, but only via redirect.
- No combinational path from any input to `ireq_valid` or `inst_valid`.

## Configuration
- `REFCPU_FETCH_ALIGN_CHECK_EN` defined:
  - In S_REQ with `pc[1:0]`≠0, no request is issued (`ireq_valid`=0).
  - Next cycle: S_HOLD with `inst_q`=0, `inst_pc_q`=`pc`, `adel_q`=1. Handshake and redirect rules are as normal.
  - Any normal load clears `adel_q`.
- Not defined:
  - `ireq_addr`={`pc[31:2]`,2'b00}.
  - `inst_adel` tied to 0.
  - `pc[1:0]` carried unchanged into `inst_pc`.

## Test plan
- Reset, `ireq_addr_ok`=1 always, response one cycle after accept with 32'h0000_0020, `inst_ready`=1 → first request addr 32'hbfc0_0000. `inst`=32'h0000_0020 with `inst_pc`=32'hbfc0_0000. Next request addr 32'hbfc0_0004 at cycle 3.
- `inst_ready`=0 for 5 cycles in S_HOLD → `inst_valid`, `inst`, `inst_pc` stable, `ireq_valid`=0. Release → `pc` advances by exactly 4.
- Redirect to 32'h8000_0100 while in S_WAIT, response arrives 2 cycles later → response discarded, `inst_valid` stays 0. Next request addr 32'h8000_0100.
- Redirect coincident with `iresp_data_ok` in S_WAIT → no `inst_valid`. Request for redirect target issued the next cycle.
- `pc`=32'hffff_fffc consumed → next request addr 32'h0000_0000.
- With `REFCPU_FETCH_ALIGN_CHECK_EN`, redirect to 32'h8000_0102 → no bus request. `inst_valid`=1, `inst_adel`=1, `inst`=0, `inst_pc`=32'h8000_0102.
